// File: rtl/cfd_pkg.sv
// Grid constants shared by the BRAM frame write and read controllers.
package cfd_pkg;
    localparam int DATA_WIDTH    = 16;
    localparam int DEPTH         = 2500;
    localparam int ADDRESS_WIDTH = 12;
endpackage

// File: rtl/axis_skid_fifo.sv
// Two-entry FIFO that buffers BRAM read data (with its tlast tag) in front of the stream port.
module axis_skid_fifo #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;

    assign head = mem[rd_ptr];

    // The caller never pushes when full or pops when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/bram_frame_reader.sv
// Streams one full frame out of the BRAM read port as an AXI-Stream packet when frame_ready pulses.
module bram_frame_reader #(
    parameter int DATA_WIDTH    = cfd_pkg::DATA_WIDTH,
    parameter int DEPTH         = cfd_pkg::DEPTH,
    parameter int ADDRESS_WIDTH = cfd_pkg::ADDRESS_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_ready,
    output logic                     bram_en,
    output logic [ADDRESS_WIDTH-1:0] bram_addr,
    input  logic [DATA_WIDTH-1:0]    bram_dout,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     overrun
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

    state_t                   state;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic                     inflight;
    logic                     inflight_last;
    logic [DATA_WIDTH:0]      head;
    logic [1:0]               count;
    logic                     pop;
    logic                     issue;
    logic [2:0]               credit;

    assign m_axis_tvalid = (count != 2'd0);
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign m_axis_tdata  = head[DATA_WIDTH-1:0];
    assign m_axis_tlast  = m_axis_tvalid && head[DATA_WIDTH];

    // A read is only issued if its data is guaranteed a FIFO slot when it returns.
    assign credit    = 3'(count) + 3'(inflight) - 3'(pop);
    assign issue     = (state == READ) && (credit <= 3'd1);
    assign bram_en   = issue;
    assign bram_addr = addr;
    assign busy      = (state != IDLE);

    axis_skid_fifo #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight),
        .push_data({inflight_last, bram_dout}),
        .pop      (pop),
        .head     (head),
        .count    (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            addr          <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            frame_done    <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue && (addr == LAST_ADDR);
            frame_done    <= 1'b0;
            overrun       <= frame_ready && (state != IDLE);
            case (state)
                IDLE: begin
                    if (frame_ready) begin
                        state <= READ;
                        addr  <= '0;
                    end
                end
                READ: begin
                    if (issue) begin
                        if (addr == LAST_ADDR) begin
                            state <= DRAIN;
                        end else begin
                            addr <= addr + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Frame ends when the tagged last word leaves the FIFO.
                    if (pop && m_axis_tlast) begin
                        state      <= IDLE;
                        addr       <= '0;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
